pll_lock_sequencer: RTL

//  Consumer side of the PLL lock interface. Runs on the free-running PLL reference clock.

---
 rtl/pll_lock_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, synchronizes and qualifies lock,
// then releases the system reset; re-runs the sequence on lock loss.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] RST_LD = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LD = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LD = TW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } st_t;

  st_t             st, st_nxt;
  logic [TW-1:0]   cnt, cnt_nxt;
  logic            sync1, lk;
  logic            loss_inc, retry_inc;

  // Two-flop synchronizer; only lk is seen by the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // Shared down-counter: reloaded on every state entry, transition fires at zero.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - 1'b1;
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (st)
      RESET_PLL: begin
        if (cnt == '0) begin
          st_nxt  = WAIT_LOCK;
          cnt_nxt = TMO_LD;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          st_nxt  = STABLE;
          cnt_nxt = STB_LD;
        end else if (cnt == '0) begin
          st_nxt    = RESET_PLL;
          cnt_nxt   = RST_LD;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lk) begin
          st_nxt  = WAIT_LOCK;
          cnt_nxt = TMO_LD;
        end else if (cnt == '0) begin
          st_nxt = RUN;
        end
      end
      RUN: begin
        if (!lk) begin
          st_nxt   = RESET_PLL;
          cnt_nxt  = RST_LD;
          loss_inc = 1'b1;
        end
      end
      default: begin
        st_nxt  = RESET_PLL;
        cnt_nxt = RST_LD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RESET_PLL;
      cnt       <= RST_LD;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      // Registered from next state so release and re-assert coincide with RUN entry/exit.
      sys_rst_n <= (st_nxt == RUN);
      ready     <= (st_nxt == RUN);
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count  <= '0;
      retry_count <= '0;
    end else if (clear_counts) begin
      loss_count  <= '0;
      retry_count <= '0;
    end else begin
      if (loss_inc && (loss_count != '1))
        loss_count <= loss_count + 1'b1;
      if (retry_inc && (retry_count != '1))
        retry_count <= retry_count + 1'b1;
    end
  end

  assign pll_rst = (st == RESET_PLL);
  assign state   = st;

endmodule
